// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - one load then N shift steps per command, fully registered controls.
// Optional SEQ_SHADOW_EN adds shadow_q, a model of the register contents.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [1:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             hold,
  output logic [WIDTH-1:0] reg_data,
  output logic             reg_load_n,
  output logic             reg_dir_right,
  output logic             reg_zero_fill,
  output logic             reg_step,
  output logic             busy,
  output logic             done
`ifdef SEQ_SHADOW_EN
  ,
  output logic [WIDTH-1:0] shadow_q
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] reg_data_q, reg_data_d;
  logic             load_n_q, load_n_d;
  logic             dir_right_q, dir_right_d;
  logic             zero_fill_q, zero_fill_d;
  logic             step_q, step_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Outputs are computed for the cycle being entered, so hold sampled in a
  // RUN cycle gates the step shown in the following cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    count_d     = count_q;
    mode_d      = mode_q;
    reg_data_d  = reg_data_q;
    load_n_d    = 1'b1;
    dir_right_d = 1'b1;
    zero_fill_d = 1'b0;
    step_d      = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LOAD;
          reg_data_d  = cmd_data;
          mode_d      = cmd_mode;
          count_d     = cmd_count;
          cnt_d       = '0;
          load_n_d    = 1'b0;
          step_d      = 1'b1;
          busy_d      = 1'b1;
          dir_right_d = ~cmd_mode[0];
          zero_fill_d = cmd_mode[1];
        end
      end
      S_LOAD: begin
        busy_d      = 1'b1;
        dir_right_d = ~mode_q[0];
        zero_fill_d = mode_q[1];
        if (count_q != '0) begin
          state_d = S_RUN;
          step_d  = 1'b1;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_RUN: begin
        busy_d      = 1'b1;
        dir_right_d = ~mode_q[0];
        zero_fill_d = mode_q[1];
        // cnt_q counts steps already issued; the last one is executing now.
        if (cnt_q == count_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (!hold) begin
          step_d = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      count_q     <= '0;
      mode_q      <= '0;
      reg_data_q  <= '0;
      load_n_q    <= 1'b1;
      dir_right_q <= 1'b1;
      zero_fill_q <= 1'b0;
      step_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      reg_data_q  <= reg_data_d;
      load_n_q    <= load_n_d;
      dir_right_q <= dir_right_d;
      zero_fill_q <= zero_fill_d;
      step_q      <= step_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign reg_data      = reg_data_q;
  assign reg_load_n    = load_n_q;
  assign reg_dir_right = dir_right_q;
  assign reg_zero_fill = zero_fill_q;
  assign reg_step      = step_q;
  assign busy          = busy_q;
  assign done          = done_q;

`ifdef SEQ_SHADOW_EN
  logic [WIDTH-1:0] shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (step_q) begin
      if (!load_n_q) begin
        shadow_d = reg_data_q;
      end else begin
        case (mode_q)
          2'b00:   shadow_d = {shadow_q[0], shadow_q[WIDTH-1:1]};
          2'b01:   shadow_d = {shadow_q[WIDTH-2:0], shadow_q[WIDTH-1]};
          2'b10:   shadow_d = {1'b0, shadow_q[WIDTH-1:1]};
          default: shadow_d = {shadow_q[WIDTH-2:0], 1'b0};
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`endif

endmodule
